// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush sequencer for the five-stage pipeline.
// Define MEM_WAIT_EN to compile in the multi-cycle data-memory handshake and timeout.
module pipeline_hazard_controller #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int STALL_CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ID_EXE_MemRead,
  input  logic [4:0]             ID_EXE_Rt,
  input  logic [4:0]             IF_ID_Rs,
  input  logic [4:0]             IF_ID_Rt,
  input  logic                   IF_ID_UsesRt,
  input  logic                   EXE_BranchTaken,
  input  logic                   EXE_MEM_MemRead,
  input  logic                   EXE_MEM_MemWrite,
  input  logic                   mem_ready,
  output logic                   PC_Write,
  output logic                   IF_ID_Write,
  output logic                   ID_EXE_Write,
  output logic                   EXE_MEM_Write,
  output logic                   IF_ID_Flush,
  output logic                   ID_EXE_Flush,
  output logic                   MEM_WB_Bubble,
  output logic                   mem_req,
  output logic                   mem_timeout,
  output logic [STALL_CNT_W-1:0] stall_count
);

  // state    | meaning
  // RUN      | pipeline advances; a memory access not ready this cycle enters MEM_WAIT
  // MEM_WAIT | pipeline frozen until mem_ready or the wait counter reaches its limit
  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  localparam logic [7:0]             WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;
  localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  logic                   hazard;
  logic                   memop;
  logic                   advance;
  logic                   abort;
  logic [STALL_CNT_W-1:0] stall_q;

  assign hazard = ID_EXE_MemRead && (ID_EXE_Rt != 5'd0) &&
                  ((ID_EXE_Rt == IF_ID_Rs) || (IF_ID_UsesRt && (ID_EXE_Rt == IF_ID_Rt)));
  assign memop  = EXE_MEM_MemRead || EXE_MEM_MemWrite;

`ifdef MEM_WAIT_EN
  state_t     state_q, state_d;
  logic [7:0] wait_q;
  logic       timeout_q;

  always_comb begin
    state_d = state_q;
    advance = 1'b1;
    abort   = 1'b0;
    mem_req = 1'b0;
    case (state_q)
      RUN: begin
        mem_req = memop;
        if (memop && !mem_ready) begin
          advance = 1'b0;
          state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          state_d = RUN;
        end else if (wait_q == WAIT_LAST) begin
          abort   = 1'b1;
          state_d = RUN;
        end else begin
          advance = 1'b0;
        end
      end
      default: state_d = RUN;
    endcase
    // reset abandons any outstanding access immediately
    if (!rst_n) mem_req = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RUN;
      wait_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == RUN) wait_q <= 8'd0;
      else if (!advance)  wait_q <= wait_q + 8'd1;
      if (abort) timeout_q <= 1'b1;
    end
  end

  assign mem_timeout = timeout_q;
`else
  logic unused_ok;
  assign unused_ok   = ^{mem_ready, memop, WAIT_LAST};
  assign advance     = 1'b1;
  assign abort       = 1'b0;
  assign mem_req     = 1'b0;
  assign mem_timeout = 1'b0;
`endif

  always_comb begin
    PC_Write      = 1'b0;
    IF_ID_Write   = 1'b0;
    ID_EXE_Write  = 1'b0;
    EXE_MEM_Write = 1'b0;
    IF_ID_Flush   = 1'b0;
    ID_EXE_Flush  = 1'b0;
    MEM_WB_Bubble = 1'b0;
    if (rst_n && advance) begin
      PC_Write      = 1'b1;
      IF_ID_Write   = 1'b1;
      ID_EXE_Write  = 1'b1;
      EXE_MEM_Write = 1'b1;
      MEM_WB_Bubble = abort;
      // a taken branch discards the decode instruction, so its hazard is moot
      if (EXE_BranchTaken) begin
        IF_ID_Flush  = 1'b1;
        ID_EXE_Flush = 1'b1;
      end else if (hazard) begin
        PC_Write     = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EXE_Flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_q <= '0;
    else if (!PC_Write && (stall_q != STALL_MAX))
      stall_q <= stall_q + STALL_ONE;
  end

  assign stall_count = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: vector table plus multi-cycle
// memory-wait, timeout, reset-abandon and saturation sequences (MEM_WAIT_EN aware).
module tb_pipeline_hazard_controller;

`ifdef MEM_WAIT_EN
  localparam bit MW = 1'b1;
`else
  localparam bit MW = 1'b0;
`endif

  // {PC_Write, IF_ID_Write, ID_EXE_Write, EXE_MEM_Write, IF_ID_Flush, ID_EXE_Flush, MEM_WB_Bubble}
  localparam logic [6:0] ADV = 7'b1111000;
  localparam logic [6:0] FRZ = 7'b0000000;
  localparam logic [6:0] HAZ = 7'b0011010;
  localparam logic [6:0] BR  = 7'b1111110;
  localparam logic [6:0] ABT = 7'b1111001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ID_EXE_MemRead, IF_ID_UsesRt, EXE_BranchTaken;
  logic [4:0] ID_EXE_Rt, IF_ID_Rs, IF_ID_Rt;
  logic       EXE_MEM_MemRead, EXE_MEM_MemWrite, mem_ready;

  logic        PC_Write, IF_ID_Write, ID_EXE_Write, EXE_MEM_Write;
  logic        IF_ID_Flush, ID_EXE_Flush, MEM_WB_Bubble, mem_req, mem_timeout;
  logic [15:0] stall_count;

  logic       s_pc, s_ifw, s_idw, s_exw, s_iff, s_idf, s_bub, s_req, s_to;
  logic [1:0] s_cnt;

  int total = 0;
  int passed = 0;
  int exp_stall;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.TIMEOUT_CYCLES(4), .STALL_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_EXE_MemRead(ID_EXE_MemRead), .ID_EXE_Rt(ID_EXE_Rt),
    .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .IF_ID_UsesRt(IF_ID_UsesRt),
    .EXE_BranchTaken(EXE_BranchTaken),
    .EXE_MEM_MemRead(EXE_MEM_MemRead), .EXE_MEM_MemWrite(EXE_MEM_MemWrite),
    .mem_ready(mem_ready),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .ID_EXE_Write(ID_EXE_Write),
    .EXE_MEM_Write(EXE_MEM_Write), .IF_ID_Flush(IF_ID_Flush), .ID_EXE_Flush(ID_EXE_Flush),
    .MEM_WB_Bubble(MEM_WB_Bubble), .mem_req(mem_req), .mem_timeout(mem_timeout),
    .stall_count(stall_count)
  );

  pipeline_hazard_controller #(.TIMEOUT_CYCLES(255), .STALL_CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .ID_EXE_MemRead(ID_EXE_MemRead), .ID_EXE_Rt(ID_EXE_Rt),
    .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .IF_ID_UsesRt(IF_ID_UsesRt),
    .EXE_BranchTaken(EXE_BranchTaken),
    .EXE_MEM_MemRead(EXE_MEM_MemRead), .EXE_MEM_MemWrite(EXE_MEM_MemWrite),
    .mem_ready(mem_ready),
    .PC_Write(s_pc), .IF_ID_Write(s_ifw), .ID_EXE_Write(s_idw),
    .EXE_MEM_Write(s_exw), .IF_ID_Flush(s_iff), .ID_EXE_Flush(s_idf),
    .MEM_WB_Bubble(s_bub), .mem_req(s_req), .mem_timeout(s_to),
    .stall_count(s_cnt)
  );

  typedef struct {
    logic       mr;
    logic [4:0] ex_rt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses;
    logic       br;
    logic       emr;
    logic       emw;
    logic [6:0] exp_o;
    logic       stall;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [6:0] outs();
    return {PC_Write, IF_ID_Write, ID_EXE_Write, EXE_MEM_Write,
            IF_ID_Flush, ID_EXE_Flush, MEM_WB_Bubble};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act === exp_v) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
  endtask

  task automatic drive(input logic mr, input logic [4:0] ex_rt, input logic [4:0] rs,
                       input logic [4:0] rt, input logic uses, input logic br,
                       input logic emr, input logic emw, input logic rdy);
    ID_EXE_MemRead   = mr;
    ID_EXE_Rt        = ex_rt;
    IF_ID_Rs         = rs;
    IF_ID_Rt         = rt;
    IF_ID_UsesRt     = uses;
    EXE_BranchTaken  = br;
    EXE_MEM_MemRead  = emr;
    EXE_MEM_MemWrite = emw;
    mem_ready        = rdy;
  endtask

  // advance to the next cycle; inputs driven and outputs sampled mid-cycle
  task automatic next_cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    next_cyc();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    next_cyc();
    next_cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[0]  = '{1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ADV, 1'b0};
    vecs[1]  = '{1'b1, 5'd5,  5'd5,  5'd0, 1'b0, 1'b0, 1'b0, 1'b0, HAZ, 1'b1};
    vecs[2]  = '{1'b1, 5'd0,  5'd0,  5'd0, 1'b1, 1'b0, 1'b0, 1'b0, ADV, 1'b0};
    vecs[3]  = '{1'b1, 5'd5,  5'd3,  5'd5, 1'b0, 1'b0, 1'b0, 1'b0, ADV, 1'b0};
    vecs[4]  = '{1'b1, 5'd5,  5'd3,  5'd5, 1'b1, 1'b0, 1'b0, 1'b0, HAZ, 1'b1};
    vecs[5]  = '{1'b0, 5'd5,  5'd5,  5'd5, 1'b1, 1'b0, 1'b0, 1'b0, ADV, 1'b0};
    vecs[6]  = '{1'b1, 5'd9,  5'd9,  5'd0, 1'b0, 1'b1, 1'b0, 1'b0, BR,  1'b0};
    vecs[7]  = '{1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 1'b1, 1'b0, 1'b0, BR,  1'b0};
    vecs[8]  = '{1'b1, 5'd6,  5'd1,  5'd6, 1'b1, 1'b0, 1'b1, 1'b0, HAZ, 1'b1};
    vecs[9]  = '{1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 1'b1, 1'b0, 1'b1, BR,  1'b0};
    vecs[10] = '{1'b1, 5'd31, 5'd31, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, HAZ, 1'b1};

    // reset: outputs forced low even though idle inputs would advance
    next_cyc();
    #1;
    chk("reset_outs", 32'(outs()), 32'(FRZ));
    chk("reset_req", 32'(mem_req), 0);
    next_cyc();
    rst_n = 1'b1;
    #1;
    chk("post_reset_stall", 32'(stall_count), 0);
    chk("post_reset_timeout", 32'(mem_timeout), 0);
    chk("post_reset_outs", 32'(outs()), 32'(ADV));

    exp_stall = 0;
    for (int i = 0; i < 11; i++) begin
      next_cyc();
      drive(vecs[i].mr, vecs[i].ex_rt, vecs[i].rs, vecs[i].rt, vecs[i].uses,
            vecs[i].br, vecs[i].emr, vecs[i].emw, 1'b1);
      #1;
      chk($sformatf("vec%0d_stall", i), 32'(stall_count), 32'(exp_stall));
      chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vecs[i].exp_o));
      chk($sformatf("vec%0d_req", i), 32'(mem_req), 32'(MW & (vecs[i].emr | vecs[i].emw)));
      if (vecs[i].stall) exp_stall++;
    end
    next_cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("table_stall_total", 32'(stall_count), 32'(exp_stall));

    // saturation on the 2-bit instance
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 5'd7, 5'd7, 5'd0, 0, 0, 0, 0, 0);
      next_cyc();
      if (i == 2) chk("sat_at3", 32'(s_cnt), 3);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("sat_hold", 32'(s_cnt), 3);
    chk("wide_count5", 32'(stall_count), 5);

`ifdef MEM_WAIT_EN
    // ready two cycles after request start: two freeze cycles
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    #1;
    chk("mw_c0_outs", 32'(outs()), 32'(FRZ));
    chk("mw_c0_req", 32'(mem_req), 1);
    next_cyc();
    drive(1, 5'd4, 5'd4, 5'd0, 0, 0, 1, 0, 0);
    #1;
    chk("mw_c1_outs_hazard_ignored", 32'(outs()), 32'(FRZ));
    chk("mw_c1_req", 32'(mem_req), 1);
    next_cyc();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 1);
    #1;
    chk("mw_c2_outs", 32'(outs()), 32'(ADV));
    chk("mw_c2_req", 32'(mem_req), 1);
    next_cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("mw_c3_req_run", 32'(mem_req), 0);
    chk("mw_c3_outs", 32'(outs()), 32'(ADV));
    chk("mw_stall2", 32'(stall_count), 2);

    // branch during freeze is ignored, applied at completion
    next_cyc();
    drive(0, 0, 0, 0, 0, 1, 0, 1, 0);
    #1;
    chk("br_freeze_outs", 32'(outs()), 32'(FRZ));
    next_cyc();
    drive(0, 0, 0, 0, 0, 1, 0, 1, 1);
    #1;
    chk("br_complete_outs", 32'(outs()), 32'(BR));
    next_cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("br_stall3", 32'(stall_count), 3);

    // ready in the request cycle costs nothing
    next_cyc();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 1);
    #1;
    chk("mw_ready0_outs", 32'(outs()), 32'(ADV));
    next_cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("mw_ready0_stall", 32'(stall_count), 3);

    // timeout: four freeze cycles, abort with bubble, sticky flag
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
      #1;
      chk($sformatf("to_c%0d_outs", c), 32'(outs()), 32'(FRZ));
      chk($sformatf("to_c%0d_req", c), 32'(mem_req), 1);
      next_cyc();
    end
    #1;
    chk("to_abort_outs", 32'(outs()), 32'(ABT));
    chk("to_abort_req", 32'(mem_req), 1);
    chk("to_abort_flag_pending", 32'(mem_timeout), 0);
    next_cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("to_flag_set", 32'(mem_timeout), 1);
    chk("to_run_req", 32'(mem_req), 0);
    chk("to_stall4", 32'(stall_count), 4);
    next_cyc();
    #1;
    chk("to_flag_sticky", 32'(mem_timeout), 1);

    // ready on the abort cycle completes normally
    do_reset();
    #1;
    chk("reset_clears_timeout", 32'(mem_timeout), 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int c = 0; c < 4; c++) next_cyc();
    mem_ready = 1'b1;
    #1;
    chk("late_ready_outs", 32'(outs()), 32'(ADV));
    next_cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("late_ready_no_timeout", 32'(mem_timeout), 0);
    chk("late_ready_stall4", 32'(stall_count), 4);

    // reset during MEM_WAIT drops mem_req at once and returns to RUN
    next_cyc();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    next_cyc();
    rst_n = 1'b0;
    #1;
    chk("rst_mw_req", 32'(mem_req), 0);
    chk("rst_mw_outs", 32'(outs()), 32'(FRZ));
    next_cyc();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_mw_run_req", 32'(mem_req), 0);
    chk("rst_mw_run_outs", 32'(outs()), 32'(ADV));
    chk("rst_mw_stall0", 32'(stall_count), 0);
`else
    // single-cycle memory: no freeze, no request, no timeout
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    #1;
    chk("nomw_outs", 32'(outs()), 32'(ADV));
    chk("nomw_req", 32'(mem_req), 0);
    next_cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    #1;
    chk("nomw_wr_outs", 32'(outs()), 32'(ADV));
    chk("nomw_timeout", 32'(mem_timeout), 0);
    next_cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("nomw_stall0", 32'(stall_count), 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
